time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
Consumer end of the divided seconds clock. Brings the slow square wave into the system clock domain and converts each rising edge into a one-cycle seconds strobe. Uses that strobe to run a 24-hour hh:mm:ss time-of-day counter with a load (set) interface and a single daily alarm. Sits between the clock divider and the display/alarm output logic of the digital clock.

Parameters:
SYNC_STAGES, 2, number of flops in the slow_clk synchroniser; legal range is 2 or more.
RING_SECS, 60, number of seconds the alarm rings before it turns off by itself; legal range 1..255.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
slow_clk  in  1  divided square wave; one rising edge per second; asynchronous to clk.
set_en  in  1  one-cycle request to load the time from set_hour, set_min and set_sec.
set_hour  in  5  hour to load, 0..23.
set_min  in  6  minute to load, 0..59.
set_sec  in  6  second to load, 0..59.
alarm_set_en  in  1  one-cycle request to load the alarm time from alarm_hour and alarm_min.
alarm_hour  in  5  alarm hour, 0..23.
alarm_min  in  6  alarm minute, 0..59.
alarm_enable  in  1  level input; alarm is armed while this is high.
alarm_stop  in  1  one-cycle request to silence a ringing alarm.
hour  out  5  current hour, 0..23.
minute  out  6  current minute, 0..59.
second  out  6  current second, 0..59.
sec_tick  out  1  one-cycle pulse per detected slow_clk rising edge.
alarm_ring  out  1  high while the alarm is sounding.
set_err  out  1  one-cycle pulse when a load request is rejected.

Behaviour:
- Single clock domain (clk). All registers use the synchronous active-high reset.
- Reset values:
  - hour, minute, second = 0; sec_tick = 0; alarm_ring = 0; set_err = 0.
  - Stored alarm time = 00:00; ring counter = 0.
  - Synchroniser and edge-history flops = 0; the "armed" flag = 0.
- Edge detection:
  - slow_clk passes through SYNC_STAGES flops; the last stage feeds a history flop.
  - A rising edge is last stage = 1 and history = 0.
  - The armed flag sets the first time the last stage is seen at 0. Edges are ignored while armed = 0, so a slow_clk that is high at reset release produces no tick.
- Latency: sec_tick and the counter update are both registered and occur on the same clk edge. That edge is exactly SYNC_STAGES+1 clk edges after the first clk edge that samples slow_clk high.
- Counting on a tick:
  - second goes 59 to 0 and carries into minute.
  - minute goes 59 to 0 and carries into hour.
  - hour goes 23 to 0.
  - 23:59:59 becomes 00:00:00 on a single edge.
- Time load (set_en):
  - If set_hour < 24, set_min < 60 and set_sec < 60, the values load on the next edge.
  - Otherwise the time is unchanged and set_err pulses on the next edge.
  - A load takes priority over a same-cycle tick: the loaded value wins, with no increment. sec_tick still pulses.
- Alarm load (alarm_set_en): valid when alarm_hour < 24 and alarm_min < 60, else rejected with set_err. set_en and alarm_set_en are evaluated independently in the same cycle; set_err pulses if either is rejected.
- Alarm trigger:
  - alarm_ring rises on the tick edge whose counter update produces hour:minute:00 equal to the stored alarm with alarm_enable = 1.
  - The ring counter loads RING_SECS at trigger.
  - Loading a time with set_en never triggers the alarm.
- Alarm termination: alarm_ring and the ring counter clear on the next edge when any of these hold:
  - alarm_stop = 1;
  - alarm_enable = 0;
  - a tick arrives with the ring counter at 1. Otherwise each tick decrements the counter.
- Stop beats trigger: if alarm_stop is high in the cycle a trigger would occur, alarm_ring stays 0.
- Re-trigger while already ringing reloads RING_SECS.
- Reset mid-ring or mid-count returns every register to its reset value on that edge. The first tick after reset requires slow_clk to go low and then high again.

Test Plan:
- Reset, slow_clk low, then 3 rising edges → sec_tick pulses exactly 3 times, each 1 cycle wide and SYNC_STAGES+1 edges after the sampling edge; time reads 00:00:03.
- set_en with 23:59:58, then 2 ticks → 23:59:59, then 00:00:00.
- set_en with set_hour=24 (later also set_sec=60) → set_err pulses once; time unchanged. Valid alarm_set_en together with an invalid set_en → alarm loads and set_err pulses.
- Alarm 07:30, alarm_enable=1, time set to 07:29:59, one tick → 07:30:00 and alarm_ring=1.
  - With RING_SECS=60, ring drops on the 60th following tick.
  - Repeat with alarm_stop after 5 ticks → ring drops on the next edge.
  - Repeat with alarm_enable dropped → ring drops on the next edge.
- slow_clk held high across reset release → no tick and no count. Then low followed by high → exactly one tick.
- set_en to 10:00:00 in the same cycle as a tick → time reads 10:00:00, not 10:00:01; sec_tick still pulses.

Source files
------------

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
//
// Consumer end of the divided seconds clock. The slow square wave is brought
// into the clk domain through a flop synchroniser, each rising edge becomes a
// one-cycle seconds strobe, and that strobe drives a 24-hour hh:mm:ss
// time-of-day counter with a load interface and a single daily alarm.
//
// Request semantics: set_en, alarm_set_en and alarm_stop are single-cycle
// requests sampled on the rising edge of clk. There is no ready/backpressure;
// every request is acted on (or rejected via set_err) on the edge that
// samples it.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   slow_clk      in   1 Hz square wave, asynchronous to clk
//   set_en        in   load hour/minute/second from set_hour/set_min/set_sec
//   set_hour      in   [4:0] hour to load, 0..23
//   set_min       in   [5:0] minute to load, 0..59
//   set_sec       in   [5:0] second to load, 0..59
//   alarm_set_en  in   load alarm time from alarm_hour/alarm_min
//   alarm_hour    in   [4:0] alarm hour, 0..23
//   alarm_min     in   [5:0] alarm minute, 0..59
//   alarm_enable  in   level; alarm is armed while high
//   alarm_stop    in   silence a ringing alarm
//   hour          out  [4:0] current hour
//   minute        out  [5:0] current minute
//   second        out  [5:0] current second
//   sec_tick      out  one-cycle pulse per detected slow_clk rising edge
//   alarm_ring    out  high while the alarm is sounding
//   set_err       out  one-cycle pulse when a load request is rejected
// -----------------------------------------------------------------------------
module time_keeper #(
    parameter int SYNC_STAGES = 2,
    parameter int RING_SECS   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       alarm_set_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_enable,
    input  logic       alarm_stop,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       sec_tick,
    output logic       alarm_ring,
    output logic       set_err
);

    localparam logic [7:0] RING_INIT = 8'(RING_SECS);

    // -------------------------------------------------------------------------
    // Synchroniser and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    // Parallel shift register of ones: marks when the last synchroniser stage
    // holds a genuine post-reset sample rather than its reset zero. Without it
    // a slow_clk held high across reset release would look like a rising edge.
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   hist_q;
    logic                   armed_q;
    logic                   rise_q;
    logic                   tick_q;

    logic sync_last;
    logic vld_last;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign vld_last  = vld_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            hist_q <= sync_last;
            if (vld_last && !sync_last) begin
                armed_q <= 1'b1;
            end
            // Edge is registered once, then the strobe and the counter update
            // happen together on the following edge.
            rise_q <= armed_q && sync_last && !hist_q;
            tick_q <= rise_q;
        end
    end

    // -------------------------------------------------------------------------
    // Request validation
    // -------------------------------------------------------------------------
    logic time_ok;
    logic alarm_ok;
    logic load_time;
    logic load_alarm;

    assign time_ok    = (set_hour < 5'd24) && (set_min < 6'd60) && (set_sec < 6'd60);
    assign alarm_ok   = (alarm_hour < 5'd24) && (alarm_min < 6'd60);
    assign load_time  = set_en && time_ok;
    assign load_alarm = alarm_set_en && alarm_ok;

    // -------------------------------------------------------------------------
    // Time-of-day counter
    // -------------------------------------------------------------------------
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       err_q, err_d;

    logic [4:0] inc_hour;
    logic [5:0] inc_min;
    logic [5:0] inc_sec;

    // Incremented time, carries rippling through in one cycle so that
    // 23:59:59 becomes 00:00:00 on a single edge.
    always_comb begin
        inc_sec  = sec_q + 6'd1;
        inc_min  = min_q;
        inc_hour = hour_q;
        if (sec_q == 6'd59) begin
            inc_sec = 6'd0;
            if (min_q == 6'd59) begin
                inc_min  = 6'd0;
                inc_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                inc_min = min_q + 6'd1;
            end
        end
    end

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        err_d  = (set_en && !time_ok) || (alarm_set_en && !alarm_ok);
        // A valid load overrides a coincident tick.
        if (load_time) begin
            hour_d = set_hour;
            min_d  = set_min;
            sec_d  = set_sec;
        end else if (rise_q) begin
            hour_d = inc_hour;
            min_d  = inc_min;
            sec_d  = inc_sec;
        end
    end

    // -------------------------------------------------------------------------
    // Alarm
    // -------------------------------------------------------------------------
    logic [4:0] al_hour_q, al_hour_d;
    logic [5:0] al_min_q, al_min_d;
    logic       ring_q, ring_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       trigger;

    // Only a counting tick can trigger; a loaded time never rings the alarm.
    assign trigger = rise_q && !load_time && alarm_enable &&
                     (inc_hour == al_hour_q) && (inc_min == al_min_q) &&
                     (inc_sec == 6'd0);

    always_comb begin
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (load_alarm) begin
            al_hour_d = alarm_hour;
            al_min_d  = alarm_min;
        end
        // Stop and disable take precedence over both a trigger and a tick.
        if (alarm_stop || !alarm_enable) begin
            ring_d     = 1'b0;
            ring_cnt_d = 8'd0;
        end else if (trigger) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_INIT;
        end else if (ring_q && rise_q) begin
            if (ring_cnt_q == 8'd1) begin
                ring_d     = 1'b0;
                ring_cnt_d = 8'd0;
            end else begin
                ring_cnt_d = ring_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            err_q      <= 1'b0;
            al_hour_q  <= 5'd0;
            al_min_q   <= 6'd0;
            ring_q     <= 1'b0;
            ring_cnt_q <= 8'd0;
        end else begin
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            err_q      <= err_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign hour       = hour_q;
    assign minute     = min_q;
    assign second     = sec_q;
    assign sec_tick   = tick_q;
    assign alarm_ring = ring_q;
    assign set_err    = err_q;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  localparam int S    = 2;
  localparam int RING = 60;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       reset;
  logic       slow_clk;
  logic       set_en;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       alarm_set_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_enable;
  logic       alarm_stop;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       sec_tick;
  logic       alarm_ring;
  logic       set_err;

  always #5 clk = ~clk;

  time_keeper #(.SYNC_STAGES(S), .RING_SECS(RING)) dut (
    .clk          (clk),
    .reset        (reset),
    .slow_clk     (slow_clk),
    .set_en       (set_en),
    .set_hour     (set_hour),
    .set_min      (set_min),
    .set_sec      (set_sec),
    .alarm_set_en (alarm_set_en),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_enable (alarm_enable),
    .alarm_stop   (alarm_stop),
    .hour         (hour),
    .minute       (minute),
    .second       (second),
    .sec_tick     (sec_tick),
    .alarm_ring   (alarm_ring),
    .set_err      (set_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (sec_tick === 1'b1) tick_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, "_hour"}, 32'(hour), 32'(h));
    check({name, "_min"}, 32'(minute), 32'(m));
    check({name, "_sec"}, 32'(second), 32'(s));
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_en   = 1'b1;
    set_hour = 5'(h);
    set_min  = 6'(m);
    set_sec  = 6'(s);
    step();
    set_en = 1'b0;
  endtask

  // Full slow_clk period; the tick lands on the S+2'th edge after raising.
  task automatic tick();
    slow_clk = 1'b1;
    repeat (S + 2) step();
    slow_clk = 1'b0;
    repeat (S + 3) step();
  endtask

  task automatic tick_measured();
    slow_clk = 1'b1;
    for (int i = 0; i < S + 1; i++) begin
      step();
      check("tick_early", 32'(sec_tick), 0);
    end
    step();
    check("tick_latency", 32'(sec_tick), 1);
    step();
    check("tick_width", 32'(sec_tick), 0);
    slow_clk = 1'b0;
    repeat (S + 3) step();
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic       set_en;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [5:0] ss;
    logic       aset;
    logic [4:0] ah;
    logic [5:0] am;
    logic [4:0] eh;
    logic [5:0] em;
    logic [5:0] es;
    logic       eerr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int t0;
    vecs[0] = '{1'b1, 5'd23, 6'd59, 6'd58, 1'b0, 5'd0,  6'd0,  5'd23, 6'd59, 6'd58, 1'b0};
    vecs[1] = '{1'b1, 5'd24, 6'd0,  6'd0,  1'b0, 5'd0,  6'd0,  5'd23, 6'd59, 6'd58, 1'b1};
    vecs[2] = '{1'b1, 5'd10, 6'd10, 6'd60, 1'b0, 5'd0,  6'd0,  5'd23, 6'd59, 6'd58, 1'b1};
    vecs[3] = '{1'b1, 5'd5,  6'd60, 6'd0,  1'b0, 5'd0,  6'd0,  5'd23, 6'd59, 6'd58, 1'b1};
    vecs[4] = '{1'b1, 5'd12, 6'd34, 6'd56, 1'b0, 5'd0,  6'd0,  5'd12, 6'd34, 6'd56, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b1, 5'd24, 6'd0,  5'd12, 6'd34, 6'd56, 1'b1};
    vecs[6] = '{1'b1, 5'd24, 6'd1,  6'd1,  1'b1, 5'd7,  6'd30, 5'd12, 6'd34, 6'd56, 1'b1};
    vecs[7] = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b1, 5'd6,  6'd60, 5'd12, 6'd34, 6'd56, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0, 5'd0,  6'd0,  5'd12, 6'd34, 6'd56, 1'b0};
    vecs[9] = '{1'b1, 5'd23, 6'd59, 6'd58, 1'b0, 5'd0,  6'd0,  5'd23, 6'd59, 6'd58, 1'b0};

    reset = 1'b1; slow_clk = 1'b0;
    set_en = 1'b0; set_hour = '0; set_min = '0; set_sec = '0;
    alarm_set_en = 1'b0; alarm_hour = '0; alarm_min = '0;
    alarm_enable = 1'b0; alarm_stop = 1'b0;

    // Reset state
    repeat (3) step();
    check_time("reset", 0, 0, 0);
    check("reset_tick", 32'(sec_tick), 0);
    check("reset_ring", 32'(alarm_ring), 0);
    check("reset_err", 32'(set_err), 0);
    reset = 1'b0;
    repeat (S + 4) step();

    // Three rising edges with latency and width checks
    for (int i = 0; i < 3; i++) tick_measured();
    check_time("three_ticks", 0, 0, 3);
    check("three_ticks_cnt", 32'(tick_cnt), 3);

    // Load vectors
    for (int i = 0; i < 10; i++) begin
      set_en = vecs[i].set_en; set_hour = vecs[i].sh; set_min = vecs[i].sm; set_sec = vecs[i].ss;
      alarm_set_en = vecs[i].aset; alarm_hour = vecs[i].ah; alarm_min = vecs[i].am;
      step();
      set_en = 1'b0; alarm_set_en = 1'b0;
      check_time($sformatf("vec%0d", i), 32'(vecs[i].eh), 32'(vecs[i].em), 32'(vecs[i].es));
      check($sformatf("vec%0d_err", i), 32'(set_err), 32'(vecs[i].eerr));
    end

    // Midnight rollover
    tick();
    check_time("roll_59", 23, 59, 59);
    tick();
    check_time("roll_00", 0, 0, 0);

    // Alarm 07:30 (loaded by vector 6), natural expiry after RING ticks
    alarm_enable = 1'b1;
    set_time(7, 29, 59);
    tick();
    check_time("alarm_trig", 7, 30, 0);
    check("alarm_trig_ring", 32'(alarm_ring), 1);
    for (int i = 0; i < RING - 1; i++) tick();
    check("ring_before_expiry", 32'(alarm_ring), 1);
    tick();
    check("ring_expired", 32'(alarm_ring), 0);
    check_time("ring_expired", 7, 31, 0);

    // alarm_stop after 5 ticks
    set_time(7, 29, 59);
    tick();
    check("stop_trig_ring", 32'(alarm_ring), 1);
    for (int i = 0; i < 5; i++) tick();
    check("stop_pre_ring", 32'(alarm_ring), 1);
    alarm_stop = 1'b1;
    step();
    alarm_stop = 1'b0;
    check("stop_ring", 32'(alarm_ring), 0);

    // alarm_enable dropped while ringing
    set_time(7, 29, 59);
    tick();
    check("dis_trig_ring", 32'(alarm_ring), 1);
    alarm_enable = 1'b0;
    step();
    check("dis_ring", 32'(alarm_ring), 0);
    alarm_enable = 1'b1;

    // Stop held through the trigger tick
    set_time(7, 29, 59);
    alarm_stop = 1'b1;
    tick();
    alarm_stop = 1'b0;
    check("stop_beats_trig", 32'(alarm_ring), 0);
    check_time("stop_beats_trig", 7, 30, 0);

    // Load coincident with a tick
    slow_clk = 1'b1;
    repeat (S + 1) step();
    set_en = 1'b1; set_hour = 5'd10; set_min = 6'd0; set_sec = 6'd0;
    step();
    set_en = 1'b0;
    check("load_tick_pulse", 32'(sec_tick), 1);
    check_time("load_tick", 10, 0, 0);
    step();
    check_time("load_tick_after", 10, 0, 0);
    slow_clk = 1'b0;
    repeat (S + 3) step();

    // Reset mid-ring with slow_clk held high across release
    set_time(7, 29, 59);
    tick();
    check("pre_reset_ring", 32'(alarm_ring), 1);
    slow_clk = 1'b1;
    reset = 1'b1;
    step();
    check("mid_ring_reset_ring", 32'(alarm_ring), 0);
    check_time("mid_ring_reset", 0, 0, 0);
    step();
    reset = 1'b0;
    t0 = tick_cnt;
    repeat (20) step();
    check("high_release_ticks", 32'(tick_cnt - t0), 0);
    check_time("high_release", 0, 0, 0);
    slow_clk = 1'b0;
    repeat (S + 3) step();
    tick_measured();
    check("first_tick_after_low", 32'(tick_cnt - t0), 1);
    check_time("first_tick_after_low", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
